// File: rtl/snake_io_sequencer.sv
// IO initiator that polls a speed register and drives a 3-segment snake around a 4-digit 7-seg display.
// Optional macro SNAKE_PAUSE_EN adds a PAUSE input that freezes the dwell countdown.
module snake_io_sequencer #(
  parameter int unsigned DELAY_BASE = 2500000
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef SNAKE_PAUSE_EN
  input  logic        PAUSE,
`endif
  input  logic [31:0] IOReadData,
  output logic [3:0]  IOAddr,
  output logic [31:0] IOWriteData,
  output logic        IOWriteEn,
  output logic [3:0]  STEP
);

  localparam logic [3:0]  ADDR_DISPLAY = 4'h0;
  localparam logic [3:0]  ADDR_SPEED   = 4'h4;
  localparam logic [25:0] BASE_W       = 26'(DELAY_BASE);

  typedef enum logic [1:0] {
    S_READ,
    S_WRITE,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic [1:0]  speed_q, speed_d;
  logic [25:0] cnt_q, cnt_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [25:0] cnt_load;
  logic        hold;
  logic        unused_rd;

  assign unused_rd = ^IOReadData[31:2];

`ifdef SNAKE_PAUSE_EN
  assign hold = PAUSE;
`else
  assign hold = 1'b0;
`endif

  function automatic logic [4:0] pos(input logic [3:0] s);
    case (s)
      4'd0:    pos = 5'd21;
      4'd1:    pos = 5'd14;
      4'd2:    pos = 5'd7;
      4'd3:    pos = 5'd0;
      4'd4:    pos = 5'd1;
      4'd5:    pos = 5'd2;
      4'd6:    pos = 5'd3;
      4'd7:    pos = 5'd10;
      4'd8:    pos = 5'd17;
      4'd9:    pos = 5'd24;
      4'd10:   pos = 5'd25;
      default: pos = 5'd26;
    endcase
  endfunction

  function automatic logic [3:0] prev_step(input logic [3:0] s);
    prev_step = (s == 4'd0) ? 4'd11 : s - 4'd1;
  endfunction

  function automatic logic [27:0] pat(input logic [3:0] s);
    logic [27:0] p;
    p = '0;
    p[pos(s)]                       = 1'b1;
    p[pos(prev_step(s))]            = 1'b1;
    p[pos(prev_step(prev_step(s)))] = 1'b1;
    pat = p;
  endfunction

  // Product taken modulo 2^26: for D = 2^26 the -1 still yields the correct all-ones load.
  assign cnt_load = BASE_W * 26'(3'd4 - {1'b0, speed_q}) - 26'd1;

  // Outputs are registered from the next state, so they always reflect the state being entered;
  // run_q holds the FSM in S_READ for the first edge after reset so IOAddr=4 is seen before any write.
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    if (!run_q) begin
      state_d = S_READ;
    end else begin
      case (state_q)
        S_READ: begin
          speed_d = IOReadData[1:0];
          state_d = S_WRITE;
        end
        S_WRITE: begin
          cnt_d   = cnt_load;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (!hold) begin
            if (cnt_q == '0) begin
              state_d = S_READ;
              step_d  = (step_q == 4'd11) ? 4'd0 : step_q + 4'd1;
            end else begin
              cnt_d = cnt_q - 26'd1;
            end
          end
        end
        default: state_d = S_READ;
      endcase
    end

    addr_d  = (state_d == S_READ) ? ADDR_SPEED : ADDR_DISPLAY;
    wen_d   = (state_d == S_WRITE);
    wdata_d = wen_d ? {4'h0, pat(step_q)} : wdata_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_READ;
      run_q   <= 1'b0;
      speed_q <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  assign IOAddr      = addr_q;
  assign IOWriteData = wdata_q;
  assign IOWriteEn   = wen_q;
  assign STEP        = step_q;

endmodule

// File: tb/tb_snake_io_sequencer.sv
// Scoreboard bench for snake_io_sequencer with DELAY_BASE=4; pause scenario built only with SNAKE_PAUSE_EN.
module tb_snake_io_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] io_rd;
  logic [3:0]  io_addr;
  logic [31:0] io_wd;
  logic        io_we;
  logic [3:0]  step;
  logic [1:0]  speed;
  logic [29:0] junk;
`ifdef SNAKE_PAUSE_EN
  logic        pause;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  step;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   ncyc       = 0;
  int   write_cnt  = 0;
  int   write_cyc  = 0;
  int   pos_tbl[12] = '{21, 14, 7, 0, 1, 2, 3, 10, 17, 24, 25, 26};

  snake_io_sequencer #(.DELAY_BASE(4)) dut (
    .CLK         (clk),
    .RESET       (rst),
`ifdef SNAKE_PAUSE_EN
    .PAUSE       (pause),
`endif
    .IOReadData  (io_rd),
    .IOAddr      (io_addr),
    .IOWriteData (io_wd),
    .IOWriteEn   (io_we),
    .STEP        (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: speed register at address 4 with noise in the ignored upper bits.
  assign io_rd = (io_addr == 4'h4) ? {junk, speed} : {junk, 2'b10};

  always @(posedge clk) junk <= 30'($urandom);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pat_model(input int s);
    logic [31:0] r;
    r = '0;
    r[pos_tbl[s]]            = 1'b1;
    r[pos_tbl[(s + 11) % 12]] = 1'b1;
    r[pos_tbl[(s + 10) % 12]] = 1'b1;
    return r;
  endfunction

  task automatic push_exp(input int s);
    exp_t e;
    e.data = pat_model(s);
    e.step = 4'(s);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!rst && io_we) begin
      exp_t e;
      write_cnt++;
      write_cyc = ncyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wdata", io_wd, e.data);
        check("wstep", 32'(step), 32'(e.step));
      end
    end
  end

  task automatic wait_write(output int c);
    int start;
    int n;
    start = write_cnt;
    n = 0;
    while (write_cnt == start && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (write_cnt == start) check("write_timeout", 32'd0, 32'd1);
    c = write_cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int w, wp, n;
    rst   = 1'b1;
    speed = 2'd3;
    junk  = '0;
`ifdef SNAKE_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(io_addr), 32'd0);
    check("rst_we", 32'(io_we), 32'd0);
    check("rst_wdata", io_wd, 32'd0);
    check("rst_step", 32'(step), 32'd0);

    push_exp(0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("edge1_addr", 32'(io_addr), 32'd4);
    check("edge1_we", 32'(io_we), 32'd0);
    @(posedge clk); #1;
    check("edge2_we", 32'(io_we), 32'd1);
    check("edge2_wdata", io_wd, 32'h06200000);
    @(negedge clk); #1;
    wp = write_cyc;
    repeat (5) @(posedge clk);
    #1;
    check("step1_at_6", 32'(step), 32'd1);

    push_exp(1);
    wait_write(w);
    check("period_s3", 32'(w - wp), 32'd6);
    wp = w;
    speed = 2'd0;

    push_exp(2);
    wait_write(w);
    check("period_pre_s0", 32'(w - wp), 32'd6);
    wp = w;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (io_addr == 4'h4) break;
      if (!io_we && io_addr == 4'h0) n++;
    end
    check("wait_len_s0", 32'(n), 32'd16);

    push_exp(3);
    wait_write(w);
    check("period_s0", 32'(w - wp), 32'd18);
    check("pat3_const", io_wd, 32'h00004081);
    wp = w;
    speed = 2'd3;

    push_exp(4);
    wait_write(w);
    check("period_s0_b", 32'(w - wp), 32'd18);
    wp = w;
    repeat (2) @(negedge clk);
    speed = 2'd1;

    push_exp(5);
    wait_write(w);
    check("dwell_kept", 32'(w - wp), 32'd6);
    wp = w;
    speed = 2'd3;

    push_exp(6);
    wait_write(w);
    check("dwell_next", 32'(w - wp), 32'd14);
    wp = w;

    for (int s = 7; s <= 17; s++) begin
      push_exp(s % 12);
      wait_write(w);
      check("period_loop", 32'(w - wp), 32'd6);
      wp = w;
      if (s == 12) check("wrap_wdata", io_wd, 32'h06200000);
    end

    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_addr", 32'(io_addr), 32'd0);
    check("midrst_we", 32'(io_we), 32'd0);
    check("midrst_wdata", io_wd, 32'd0);
    check("midrst_step", 32'(step), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp(0);
    wait_write(w);
    wp = w;

`ifdef SNAKE_PAUSE_EN
    begin
      int we_seen;
      we_seen = 0;
      push_exp(1);
      repeat (2) begin
        @(negedge clk); #1;
      end
      pause = 1'b1;
      repeat (10) begin
        @(posedge clk); #1;
        if (io_we) we_seen++;
      end
      pause = 1'b0;
      wait_write(w);
      check("pause_period", 32'(w - wp), 32'd16);
      check("pause_we", 32'(we_seen), 32'd0);
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
